// File: rtl/memctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package memctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic RAM_RD = 1'b0;
  localparam logic RAM_WR = 1'b1;

  function automatic int unsigned len_w(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/mc_prio_pick.sv
// Fixed-priority picker: lowest eligible index wins.
module mc_prio_pick #(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig,
  output logic [N-1:0]     onehot_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    any_c    = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        onehot_c    = '0;
        onehot_c[i] = 1'b1;
        idx_c       = IDX_W'(i);
        any_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memctrl_arb.sv
// Multi-channel byte-serial memory controller: arbitrates NCH requesters onto
// a single-byte RAM port, moving 1..LINE_BYTES bytes per transfer.
module memctrl_arb
  import memctrl_pkg::*;
#(
  parameter int unsigned     NCH        = 3,
  parameter int unsigned     ADDR_W     = 32,
  parameter int unsigned     LINE_BYTES = 16,
  parameter logic [NCH-1:0]  ABORT_MASK = 3'b010,
  localparam int unsigned    LEN_W      = len_w(LINE_BYTES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         abort,
  input  logic [NCH-1:0]               req_valid,
  input  logic [NCH-1:0]               req_write,
  input  logic [NCH*ADDR_W-1:0]        req_addr,
  input  logic [NCH*LEN_W-1:0]         req_len,
  input  logic [NCH*LINE_BYTES*8-1:0]  req_wdata,
  output logic [NCH-1:0]               done,
  output logic [LINE_BYTES*8-1:0]      rdata,
  output logic                         busy,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic                         ram_wr,
  output logic [7:0]                   ram_wdata,
  input  logic [7:0]                   ram_rdata
);

  localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  state_t             state;
  logic [IDX_W-1:0]   ch_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LINE_W-1:0]  wdata_q;
  logic [LINE_W-1:0]  line_buf;
  logic [LEN_W:0]     iss_cnt;
  logic [LEN_W-1:0]   cap_cnt;
  logic [1:0]         cap_pipe;
  logic               wr_reg;

  logic [ADDR_W-1:0]  addr_arr  [NCH];
  logic [LEN_W-1:0]   len_arr   [NCH];
  logic [LINE_W-1:0]  wdata_arr [NCH];

  logic [NCH-1:0]     ch_onehot_c;
  logic [NCH-1:0]     elig_c;
  logic [NCH-1:0]     pick_onehot_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_any_c;
  logic               pick_wr_c;
  logic               issue_c;
  logic               abort_hit_c;
  logic               wr_done_c;
  logic               rd_done_c;
  logic               accept_c;
  logic [LINE_W-1:0]  cap_merge_c;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]   = req_len[g*LEN_W +: LEN_W];
    assign wdata_arr[g] = req_wdata[g*LINE_W +: LINE_W];
  end

  // A stalled cycle must not repeat the pending write.
  assign ram_wr = wr_reg & rdy;

  assign ch_onehot_c = NCH'(1) << ch_q;
  assign issue_c     = iss_cnt <= {1'b0, len_q};
  assign abort_hit_c = (state == ST_READ) && abort && ABORT_MASK[ch_q];
  assign wr_done_c   = (state == ST_WRITE) && !issue_c;
  assign rd_done_c   = (state == ST_READ) && !abort_hit_c && cap_pipe[1] &&
                       (cap_cnt == len_q);

  // The completing channel and abortable channels sit out this edge's grant.
  assign elig_c = req_valid & ~done & ~(abort ? ABORT_MASK : '0) &
                  ~((wr_done_c || rd_done_c) ? ch_onehot_c : '0);

  mc_prio_pick #(.N(NCH)) u_pick (
    .elig     (elig_c),
    .onehot_c (pick_onehot_c),
    .idx_c    (pick_idx_c),
    .any_c    (pick_any_c)
  );

  assign pick_wr_c = |(req_write & pick_onehot_c);
  assign accept_c  = pick_any_c && ((state == ST_IDLE) || wr_done_c || rd_done_c);

  always_comb begin
    cap_merge_c = line_buf;
    cap_merge_c[{cap_cnt, 3'b000} +: 8] = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      ram_addr  <= '0;
      wr_reg    <= RAM_RD;
      ram_wdata <= '0;
      line_buf  <= '0;
      iss_cnt   <= '0;
      cap_cnt   <= '0;
      cap_pipe  <= '0;
      ch_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
    end else if (rdy) begin
      done <= '0;
      case (state)
        ST_WRITE: begin
          if (wr_done_c) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            wr_reg <= RAM_RD;
            done   <= ch_onehot_c;
          end else begin
            ram_addr  <= addr_q + ADDR_W'(iss_cnt);
            ram_wdata <= wdata_q[{iss_cnt[LEN_W-1:0], 3'b000} +: 8];
            iss_cnt   <= iss_cnt + (LEN_W+1)'(1);
          end
        end
        ST_READ: begin
          if (abort_hit_c) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            cap_pipe <= '0;
          end else begin
            // cap_pipe tracks which in-flight addresses return data two edges later
            cap_pipe <= {cap_pipe[0], issue_c};
            if (issue_c) begin
              ram_addr <= addr_q + ADDR_W'(iss_cnt);
              iss_cnt  <= iss_cnt + (LEN_W+1)'(1);
            end
            if (cap_pipe[1]) begin
              line_buf <= cap_merge_c;
              cap_cnt  <= cap_cnt + LEN_W'(1);
            end
            if (rd_done_c) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= ch_onehot_c;
              rdata <= cap_merge_c;
            end
          end
        end
        default: ;
      endcase

      if (accept_c) begin
        state    <= pick_wr_c ? ST_WRITE : ST_READ;
        busy     <= 1'b1;
        ch_q     <= pick_idx_c;
        addr_q   <= addr_arr[pick_idx_c];
        len_q    <= len_arr[pick_idx_c];
        wdata_q  <= wdata_arr[pick_idx_c];
        ram_addr <= addr_arr[pick_idx_c];
        iss_cnt  <= (LEN_W+1)'(1);
        cap_cnt  <= '0;
        if (pick_wr_c) begin
          wr_reg    <= RAM_WR;
          ram_wdata <= wdata_arr[pick_idx_c][7:0];
          cap_pipe  <= '0;
        end else begin
          wr_reg   <= RAM_RD;
          cap_pipe <= 2'b01;
          line_buf <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memctrl_arb.sv
// Bench for memctrl_arb: table vectors, hand sequences and randomized
// transactions against a transaction-level reference model.
module tb_memctrl_arb;

  localparam int NCYC = 80;
  localparam logic [2:0] MASK = 3'b010;

  logic         clk = 1'b0;
  logic         rst, rdy, abort;
  logic [2:0]   req_valid, req_write;
  logic [95:0]  req_addr;
  logic [11:0]  req_len;
  logic [383:0] req_wdata;
  logic [2:0]   done;
  logic [127:0] rdata;
  logic         busy, ram_wr;
  logic [31:0]  ram_addr;
  logic [7:0]   ram_wdata, ram_rdata;

  memctrl_arb #(.NCH(3), .ADDR_W(32), .LINE_BYTES(16), .ABORT_MASK(3'b010)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .abort(abort),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata),
    .done(done), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;
  wr_t        wlog[$];
  logic [7:0] mem     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  bit         rdy_v [NCYC];
  bit         ab_v  [NCYC];
  int         passes = 0;
  int         total  = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a[7:0];
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] a, input int len);
    logic [127:0] r = '0;
    for (int i = 0; i <= len; i++) r[i*8 +: 8] = ref_rd(a + 32'(i));
    return r;
  endfunction

  // Synchronous RAM: one-cycle read latency, frozen together with the controller.
  always @(posedge clk) begin
    if (rdy) ram_rdata <= ram_rd(ram_addr);
    if (ram_wr) begin
      mem[ram_addr] = ram_wdata;
      wlog.push_back('{a: ram_addr, d: ram_wdata});
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input int ch, input bit wr, input logic [31:0] a, input int len,
                         input logic [127:0] wd);
    req_write[ch]          = wr;
    req_addr[ch*32 +: 32]  = a;
    req_len[ch*4 +: 4]     = 4'(len);
    req_wdata[ch*128 +: 128] = wd;
    req_valid[ch]          = 1'b1;
  endtask

  task automatic clear_vec();
    for (int e = 0; e < NCYC; e++) begin
      rdy_v[e] = 1'b1;
      ab_v[e]  = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, 128'(done), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_busy"}, 128'(busy), 0);
    chk({tag, "_ram_addr"}, 128'(ram_addr), 0);
    chk({tag, "_ram_wr"}, 128'(ram_wr), 0);
    chk({tag, "_ram_wdata"}, 128'(ram_wdata), 0);
  endtask

  // One transfer on an idle block, with per-edge rdy/abort from rdy_v/ab_v.
  // The model works purely in terms of edges: accept at the first usable edge,
  // then L (write) or L+1 (read) rdy-high edges to completion.
  task automatic run_txn(input int ch, input bit wr, input logic [31:0] a, input int len,
                         input logic [127:0] wd, output int got_edge,
                         output logic [127:0] got_rdata);
    int acc = -1, need, cnt = 0, exp_edge = -1, ab_edge = -1, end_edge;
    int bad_busy = 0, bad_wr = 0, bad_log = 0;
    logic [2:0] got_done = '0;
    for (int e = 0; e < NCYC; e++)
      if (acc < 0 && rdy_v[e] && !(ab_v[e] && MASK[ch])) acc = e;
    need = wr ? len + 1 : len + 2;
    for (int e = acc + 1; e < NCYC; e++) begin
      if (rdy_v[e]) begin
        cnt++;
        if (!wr && MASK[ch] && ab_v[e]) begin ab_edge = e; break; end
        if (cnt == need) begin exp_edge = e; break; end
      end
    end
    end_edge = (exp_edge >= 0) ? exp_edge : ab_edge;
    wlog.delete();
    got_edge  = -1;
    got_rdata = '0;
    for (int e = 0; e < NCYC; e++) begin
      @(negedge clk);
      if (e == 0) set_req(ch, wr, a, len, wd);
      if (got_edge >= 0 || (ab_edge >= 0 && e > ab_edge)) req_valid[ch] = 1'b0;
      rdy   = rdy_v[e];
      abort = ab_v[e];
      @(posedge clk);
      #1;
      if (done != 0 && got_edge < 0) begin
        got_edge  = e;
        got_done  = done;
        got_rdata = rdata;
      end
      if (busy !== (e >= acc && e < end_edge)) bad_busy++;
      if (ram_wr !== (wr && e >= acc && e < end_edge && rdy_v[e])) bad_wr++;
    end
    @(negedge clk);
    rdy = 1'b1;
    abort = 1'b0;
    req_valid[ch] = 1'b0;
    chk("done_edge", 128'(got_edge), 128'(exp_edge));
    if (exp_edge >= 0) begin
      chk("done_ch", 128'(got_done), 128'(3'b001 << ch));
      if (!wr) chk("rdata", got_rdata, exp_line(a, len));
    end
    chk("busy_window", 128'(bad_busy), 0);
    chk("ram_wr_window", 128'(bad_wr), 0);
    if (wr && exp_edge >= 0) begin
      if (wlog.size() != len + 1) bad_log = 1000 + wlog.size();
      else
        for (int k = 0; k <= len; k++)
          if (wlog[k].a !== a + 32'(k) || wlog[k].d !== wd[k*8 +: 8]) bad_log++;
      for (int k = 0; k <= len; k++) ref_mem[a + 32'(k)] = wd[k*8 +: 8];
    end else if (wlog.size() != 0) bad_log = 1000 + wlog.size();
    chk("write_log", 128'(bad_log), 0);
  endtask

  typedef struct {
    int           ch;
    bit           wr;
    logic [31:0]  addr;
    int           len;
    logic [127:0] wdata;
    int           lat;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t         vecs[8];
  int           g, e0, e1;
  logic [127:0] r, r0;
  logic         busy_at;

  initial begin
    vecs[0] = '{2, 1'b1, 32'h0000_0100, 3, 128'hDDCCBBAA, 4, 128'h0};
    vecs[1] = '{0, 1'b0, 32'h0000_0200, 15, 128'h0, 17, 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[2] = '{1, 1'b0, 32'hFFFF_FFFF, 0, 128'h0, 2, 128'hFF};
    vecs[3] = '{1, 1'b0, 32'hFFFF_FFFF, 1, 128'h0, 3, 128'h00FF};
    vecs[4] = '{0, 1'b0, 32'h0000_0100, 3, 128'h0, 5, 128'hDDCCBBAA};
    vecs[5] = '{2, 1'b1, 32'hFFFF_FFFE, 2, 128'h332211, 3, 128'h0};
    vecs[6] = '{1, 1'b0, 32'hFFFF_FFFE, 3, 128'h0, 5, 128'h01332211};
    vecs[7] = '{2, 1'b1, 32'h0000_0040, 0, 128'h5A, 1, 128'h0};

    rst = 1'b1; rdy = 1'b1; abort = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    clear_vec();
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata, g, r);
      chk($sformatf("vec%0d_latency", i), 128'(g), 128'(vecs[i].lat));
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
    end

    // Channels 0 and 1 together: 0 first, 1 accepted on the edge of done[0].
    wlog.delete();
    @(negedge clk);
    set_req(0, 1'b0, 32'h200, 1, '0);
    set_req(1, 1'b1, 32'h300, 0, 128'h77);
    e0 = -1; e1 = -1; busy_at = 1'b0; r0 = '0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (done[0] && e0 < 0) begin e0 = e; busy_at = busy; r0 = rdata; end
      if (done[1] && e1 < 0) e1 = e;
      @(negedge clk);
      if (done[0]) req_valid[0] = 1'b0;
      if (done[1]) req_valid[1] = 1'b0;
    end
    req_valid = '0;
    ref_mem[32'h300] = 8'h77;
    chk("pair_done0_edge", 128'(e0), 3);
    chk("pair_busy_at_done0", 128'(busy_at), 1);
    chk("pair_rdata0", r0, 128'h0100);
    chk("pair_done1_edge", 128'(e1), 4);
    chk("pair_write_count", 128'(wlog.size()), 1);
    if (wlog.size() == 1) chk("pair_write", 128'(wlog[0]), 128'({32'h300, 8'h77}));

    // Abort mid-read on channel 1, then a normal grant.
    clear_vec(); ab_v[3] = 1'b1;
    run_txn(1, 1'b0, 32'h200, 3, '0, g, r);
    chk("abort_read_no_done", 128'(g), 128'(-1));
    clear_vec();
    run_txn(1, 1'b0, 32'h205, 0, '0, g, r);
    chk("after_abort_latency", 128'(g), 2);
    chk("after_abort_rdata", r, 128'h05);
    // Abort during a channel 2 write is ignored.
    clear_vec(); ab_v[2] = 1'b1;
    run_txn(2, 1'b1, 32'h180, 3, 128'h44332211, g, r);
    chk("abort_write_latency", 128'(g), 4);
    // Three stalled cycles mid-write push done out by three edges.
    clear_vec(); rdy_v[2] = 1'b0; rdy_v[3] = 1'b0; rdy_v[4] = 1'b0;
    run_txn(2, 1'b1, 32'h1C0, 3, 128'h88776655, g, r);
    chk("stall_write_latency", 128'(g), 7);

    for (int t = 0; t < 120; t++) begin
      int ch, len;
      bit wr;
      logic [31:0] a;
      logic [127:0] wd;
      ch  = $urandom_range(0, 2);
      wr  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 15);
      a   = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 1023));
      wd  = {$urandom, $urandom, $urandom, $urandom};
      for (int e = 0; e < NCYC; e++) begin
        rdy_v[e] = (e >= 40) || ($urandom_range(0, 3) != 0);
        ab_v[e]  = (e < 40) && ($urandom_range(0, 7) == 0);
      end
      run_txn(ch, wr, a, len, wd, g, r);
    end

    // Reset in the middle of a long read: outputs clear and no done follows.
    clear_vec();
    @(negedge clk);
    set_req(0, 1'b0, 32'h200, 15, '0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    e0 = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (done != 0) e0++;
    end
    chk("mid_reset_no_done", 128'(e0), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
